// File: rtl/decimation.sv
// Boxcar-average decimator: sums 2^SAMPLE_RATE offset-binary ADC samples and writes their mean to a FIFO.
// Define DECIM_ROUND_EN to round half up instead of truncating toward -inf.
module decimation #(
    parameter int SAMPLE_RATE = 4,
    parameter int DATAWIDTH   = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [DATAWIDTH-1:0] dataIn,
    input  logic                 full,
    output logic [DATAWIDTH-1:0] dec_data,
    output logic                 wr_en,
    output logic                 overflow
);
    localparam int AW = DATAWIDTH + SAMPLE_RATE;

    typedef enum logic {S_IDLE, S_HELD} state_t;

    state_t                 state, state_n;
    logic [SAMPLE_RATE-1:0] cnt;
    logic [AW-1:0]          acc, sum;
    logic [DATAWIDTH-1:0]   s_in, avg, avg_ob;
    logic [DATAWIDTH-1:0]   hold, hold_n, dec_n;
    logic                   done, wr_n, ovf_n;

    assign s_in = {~dataIn[DATAWIDTH-1], dataIn[DATAWIDTH-2:0]};
    assign sum  = acc + {{SAMPLE_RATE{s_in[DATAWIDTH-1]}}, s_in};
    assign done = ena && (cnt == '1);

    // Dropping the low SAMPLE_RATE bits is the arithmetic shift; rounding adds the
    // carry that +2^(SAMPLE_RATE-1) would produce into the kept bits.
`ifdef DECIM_ROUND_EN
    assign avg = sum[AW-1:SAMPLE_RATE] + DATAWIDTH'(sum[SAMPLE_RATE-1]);
`else
    assign avg = sum[AW-1:SAMPLE_RATE];
`endif
    assign avg_ob = {~avg[DATAWIDTH-1], avg[DATAWIDTH-2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (ena) begin
            cnt <= cnt + SAMPLE_RATE'(1);
            acc <= done ? '0 : sum;
        end
    end

    // S_HELD: one finished block waits in hold; the oldest result wins when both are blocked.
    always_comb begin
        state_n = state;
        hold_n  = hold;
        dec_n   = dec_data;
        wr_n    = 1'b0;
        ovf_n   = overflow;
        case (state)
            S_IDLE: begin
                if (done) begin
                    if (!full) begin
                        wr_n  = 1'b1;
                        dec_n = avg_ob;
                    end else begin
                        hold_n  = avg_ob;
                        state_n = S_HELD;
                    end
                end
            end
            S_HELD: begin
                if (!full) begin
                    wr_n  = 1'b1;
                    dec_n = hold;
                    if (done) hold_n = avg_ob;
                    else      state_n = S_IDLE;
                end else if (done) begin
                    ovf_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            hold     <= '0;
            dec_data <= '0;
            wr_en    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            hold     <= hold_n;
            dec_data <= dec_n;
            wr_en    <= wr_n;
            overflow <= ovf_n;
        end
    end
endmodule

// File: tb/tb_decimation.sv
// Self-checking bench for decimation: directed scenarios plus a random run against an arithmetic block-average model.
module tb_decimation;
    localparam int DW   = 14;
    localparam int SR   = 4;
    localparam int BLK  = 1 << SR;
    localparam int HALF = 1 << (DW - 1);

    logic          clk = 1'b0;
    logic          rst, ena, full;
    logic [DW-1:0] dataIn, dec_data;
    logic          wr_en, overflow;

    int checks = 0, failures = 0;

    // reference model state
    int            m_n, m_sum;
    bit            m_hv, m_wr, m_ovf;
    logic [DW-1:0] m_h, m_dec;
    // write tallies (DUT and model)
    int            nw, wat, cycn, m_nw;
    logic [DW-1:0] wlast, m_wlast;

    decimation #(.SAMPLE_RATE(SR), .DATAWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .dataIn(dataIn), .full(full),
        .dec_data(dec_data), .wr_en(wr_en), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Mean of a block of signed samples, floor division (or round half up), back to offset binary.
    function automatic logic [DW-1:0] blk_avg(input int s);
        int a;
`ifdef DECIM_ROUND_EN
        s = s + BLK / 2;
`endif
        a = (s - (((s % BLK) + BLK) % BLK)) / BLK;
        return DW'(a + HALF);
    endfunction

    // One clock: drive inputs, advance the model, then sample #1 after the edge.
    task automatic cyc(input bit r, input bit e, input logic [DW-1:0] d, input bit f);
        bit            done;
        logic [DW-1:0] bv;
        rst = r; ena = e; dataIn = d; full = f;
        m_wr = 1'b0;
        done = 1'b0;
        bv   = '0;
        if (r) begin
            m_n = 0; m_sum = 0; m_hv = 0; m_h = '0; m_dec = '0; m_ovf = 0;
        end else begin
            if (e) begin
                m_sum += int'(d) - HALF;
                m_n++;
                if (m_n == BLK) begin
                    done = 1'b1; bv = blk_avg(m_sum); m_sum = 0; m_n = 0;
                end
            end
            if (m_hv) begin
                if (!f) begin
                    m_wr = 1'b1; m_dec = m_h;
                    if (done) m_h = bv; else m_hv = 0;
                end else if (done) m_ovf = 1'b1;
            end else if (done) begin
                if (!f) begin m_wr = 1'b1; m_dec = bv; end
                else begin m_h = bv; m_hv = 1'b1; end
            end
        end
        if (m_wr) begin m_nw++; m_wlast = m_dec; end
        @(posedge clk); #1;
        if (wr_en === 1'b1) begin nw++; wat = cycn; wlast = dec_data; end
        cycn++;
    endtask

    task automatic clr();
        nw = 0; wat = -1; cycn = 0; m_nw = 0; wlast = '0; m_wlast = '0;
    endtask

    task automatic do_reset();
        cyc(1, 0, '0, 0);
        clr();
    endtask

    task automatic feed(input int n, input logic [DW-1:0] d, input bit f);
        for (int i = 0; i < n; i++) cyc(0, 1, d, f);
    endtask

    task automatic test_reset();
        cyc(0, 1, 14'h3FFF, 0);
        cyc(1, 1, 14'h3FFF, 0);
        checks++;
        if (wr_en !== 1'b0 || dec_data !== '0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state wr_en=%b dec_data=%h overflow=%b required 0/0000/0", wr_en, dec_data, overflow);
        end
        clr();
    endtask

    task automatic test_midscale();
        do_reset();
        feed(BLK, 14'h2000, 0);
        cyc(0, 0, '0, 0);
        cyc(0, 0, '0, 0);
        checks++;
        if (nw !== 1 || wat !== BLK - 1) begin
            failures++;
            $display("FAIL midscale_pulse writes=%0d at=%0d required 1 at %0d", nw, wat, BLK - 1);
        end
        checks++;
        if (wlast !== 14'h2000) begin
            failures++;
            $display("FAIL midscale_data got=%h required 2000", wlast);
        end
    endtask

    task automatic test_ramp();
        logic [DW-1:0] exp_v;
`ifdef DECIM_ROUND_EN
        exp_v = 14'h2008;
`else
        exp_v = 14'h2007;
`endif
        do_reset();
        for (int k = 0; k < BLK; k++) cyc(0, 1, DW'(14'h2000 + k), 0);
        checks++;
        if (nw !== 1 || wlast !== exp_v) begin
            failures++;
            $display("FAIL ramp writes=%0d got=%h required 1 of %h", nw, wlast, exp_v);
        end
    endtask

    task automatic test_extremes();
        do_reset();
        feed(BLK, 14'h0000, 0);
        checks++;
        if (nw !== 1 || wlast !== 14'h0000) begin
            failures++;
            $display("FAIL extreme_low writes=%0d got=%h required 1 of 0000", nw, wlast);
        end
        clr();
        feed(BLK, 14'h3FFF, 0);
        checks++;
        if (nw !== 1 || wlast !== 14'h3FFF) begin
            failures++;
            $display("FAIL extreme_high writes=%0d got=%h required 1 of 3fff", nw, wlast);
        end
    endtask

    task automatic test_gapped();
        do_reset();
        for (int i = 0; i < 2 * BLK; i++) cyc(0, (i % 2) == 0, 14'h3000, 0);
        checks++;
        if (nw !== 1 || wat !== 2 * BLK - 2 || wlast !== 14'h3000) begin
            failures++;
            $display("FAIL gapped writes=%0d at=%0d got=%h required 1 at %0d of 3000", nw, wat, wlast, 2 * BLK - 2);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        feed(BLK, 14'h2345, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1);
        checks++;
        if (nw !== 0) begin
            failures++;
            $display("FAIL bp_no_early writes=%0d required 0", nw);
        end
        cyc(0, 0, '0, 0);
        checks++;
        if (wr_en !== 1'b1 || dec_data !== 14'h2345) begin
            failures++;
            $display("FAIL bp_release wr_en=%b dec_data=%h required 1/2345", wr_en, dec_data);
        end
        cyc(0, 0, '0, 0);
        checks++;
        if (nw !== 1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL bp_after writes=%0d overflow=%b required 1/0", nw, overflow);
        end
    endtask

    task automatic test_drop();
        do_reset();
        feed(BLK, 14'h2100, 1);
        feed(BLK, 14'h2200, 1);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL drop_overflow overflow=%b required 1", overflow);
        end
        for (int i = 0; i < 40 - 2 * BLK; i++) cyc(0, 0, '0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, '0, 0);
        checks++;
        if (nw !== 1 || wlast !== 14'h2100 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL drop_release writes=%0d got=%h overflow=%b required 1 of 2100, 1", nw, wlast, overflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        feed(7, 14'h3FFF, 0);
        cyc(1, 0, '0, 0);
        checks++;
        if (wr_en !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_wr wr_en=%b required 0", wr_en);
        end
        clr();
        feed(BLK - 1, 14'h2000, 0);
        checks++;
        if (nw !== 0) begin
            failures++;
            $display("FAIL rstmid_early writes=%0d required 0", nw);
        end
        feed(1, 14'h2000, 0);
        checks++;
        if (nw !== 1 || wlast !== 14'h2000 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_data writes=%0d got=%h overflow=%b required 1 of 2000, 0", nw, wlast, overflow);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 500) == 0, ($urandom % 4) != 0, DW'($urandom), ($urandom % 3) == 0);
            checks++;
            if (wr_en !== m_wr || dec_data !== m_dec || overflow !== m_ovf) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random cyc=%0d wr_en=%b dec=%h ovf=%b required %b/%h/%b",
                             i, wr_en, dec_data, overflow, m_wr, m_dec, m_ovf);
            end
        end
        checks++;
        if (nw !== m_nw || wlast !== m_wlast) begin
            failures++;
            $display("FAIL random_tally writes=%0d last=%h required %0d/%h", nw, wlast, m_nw, m_wlast);
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; full = 1'b0; dataIn = '0;
        clr();
        test_reset();
        test_midscale();
        test_ramp();
        test_extremes();
        test_gapped();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decimation.md
Name: decimation

Overview:
- ADC-side counterpart of the DAC-path interpolator: reduces the sample rate by 2^SAMPLE_RATE using a boxcar-average decimator.
- Takes offset-binary ADC samples qualified by ena and accumulates each block of 2^SAMPLE_RATE accepted samples as two's complement.
- Writes one offset-binary averaged sample per block into the downstream FIFO via a wr_en pulse, honouring its full flag through a one-entry holding register.

Parameters:
- SAMPLE_RATE, 4, log2 of decimation factor (block = 16 samples by default).
- DATAWIDTH, 14, sample width in and out, offset binary.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  input sample valid; dataIn accepted on every rising clk edge with ena=1.
- dataIn  in  DATAWIDTH  ADC sample, offset binary (0 = most negative, 2^(DATAWIDTH-1) = zero).
- full  in  1  downstream FIFO full; no write may be issued while sampled high.
- dec_data  out  DATAWIDTH  decimated sample, offset binary; valid when wr_en=1, holds its value otherwise.
- wr_en  out  1  single-cycle FIFO write strobe.
- overflow  out  1  sticky: a completed block result was dropped.

Behaviour:
- Reset: all outputs 0; sample counter, accumulator, holding register and pending flag all cleared. Reset mid-block discards the partial block; the next block needs a full 2^SAMPLE_RATE fresh samples.
- Input conversion: s_in = {~dataIn[MSB], dataIn[MSB-1:0]}, signed DATAWIDTH bits.
- Accumulator: signed DATAWIDTH+SAMPLE_RATE bits; it cannot overflow.
- Sample counter: SAMPLE_RATE bits, advances only on accepted samples (ena=1). Cycles with ena=0 change nothing in the accumulate path.
- Block completion: occurs on the accepted sample with counter = 2^SAMPLE_RATE-1.
  - sum = acc + s_in.
  - avg = sum >>> SAMPLE_RATE (arithmetic shift; truncation toward −inf).
  - acc <= 0; counter wraps to 0.
  - The completing sample is included in this block; the next sample starts a new block.
- Output conversion: dec_data = {~avg[MSB], avg[MSB-1:0]}.
- Output state machine (pending flag P, holding register H):
  - Completion, P=0, full=0: next edge wr_en=1 and dec_data=avg. Latency is 1 clk after the last sample edge.
  - Completion, P=0, full=1: H<=avg, P<=1, wr_en=0.
  - P=1, full=0, no completion: next edge wr_en=1, dec_data=H, P<=0.
  - P=1, full=0, with completion: next edge write H, H<=avg, P stays 1.
  - P=1, full=1, with completion: avg dropped, H kept (oldest wins), overflow<=1.
  - Otherwise wr_en=0.
- wr_en is never high two cycles in a row unless both a drained H and a new completion fall in consecutive cycles; each wr_en corresponds to exactly one block.
- overflow is cleared only by rst.

Optional Feature:
- DECIM_ROUND_EN defined: avg = (sum + 2^(SAMPLE_RATE-1)) >>> SAMPLE_RATE (round half up). The width is unchanged; the maximum sum plus the rounding constant still fits.
- Not defined: truncation as above, no adder in the output path.

Test Plan:
- Midscale: 16 samples of 14'h2000, ena=1 continuous, full=0 -> exactly one wr_en pulse, 1 clk after the 16th sample, dec_data=14'h2000.
- Ramp: 14'h2000+k for k=0..15 -> dec_data=14'h2007 (truncation); 14'h2008 with DECIM_ROUND_EN. Extremes: 16×14'h0000 -> 14'h0000; 16×14'h3FFF -> 14'h3FFF in both builds.
- Gapped ena: ena alternating 1/0, 32 cycles of constant 14'h3000 -> one wr_en with dec_data=14'h3000, issued the cycle after the 16th accepted sample; no write earlier.
- Backpressure: full=1 at completion, released 5 clks later -> wr_en exactly 1 clk after full first samples low, with the held value; overflow stays 0.
- Drop: full held high for 40 clks across two completions (block A value 14'h2100, block B 14'h2200) -> overflow=1 after the 2nd completion; on release a single write of 14'h2100; block B is never written.
- Reset mid-block: 7 samples of 14'h3FFF, pulse rst, then 16 samples of 14'h2000 -> dec_data=14'h2000, overflow=0, wr_en=0 throughout the reset cycle.
